// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU: operands in from EX, quotient/remainder out as lo/hi.
// Takes WIDTH+1 cycles from start to result (1 cycle for divide-by-zero) and holds the result while hold is high.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    input  logic             hold,
    output logic             stall_req,
    output logic             result_valid,
    output logic             lo_we,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             hi_we,
    output logic [WIDTH-1:0] hi_wdata
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // One restoring step: the extra top bit of diff is the borrow of the trial subtract.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        rem_nx = rem_sh[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end
        a_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_abs = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (annul) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            lo_q  <= '1;
                            hi_q  <= dividend;
                            state <= DONE;
                        end else begin
                            quo   <= a_abs;
                            dvs   <= b_abs;
                            rem   <= '0;
                            cnt   <= '0;
                            q_neg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg <= signed_op & dividend[WIDTH-1];
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        lo_q  <= q_neg ? -quo_nx : quo_nx;
                        hi_q  <= r_neg ? -rem_nx : rem_nx;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!hold) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stall_req must see this cycle's start, so it cannot wait for a register.
    assign stall_req    = ~annul & (((state == IDLE) & start) | (state == BUSY));
    assign result_valid = (state == DONE);
    assign lo_we        = result_valid;
    assign hi_we        = result_valid;
    assign lo_wdata     = lo_q;
    assign hi_wdata     = hi_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed literal cases plus random traffic against a cycle-level behavioural model.
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, signed_op, annul, hold;
    logic [31:0] dividend, divisor;
    logic        stall_req, result_valid, lo_we, hi_we;
    logic [31:0] lo_wdata, hi_wdata;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: busy_left counts remaining iteration cycles, m_done marks a presented result.
    int          busy_left = 0;
    bit          m_done    = 1'b0;
    logic [31:0] m_lo, m_hi;

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .annul(annul), .hold(hold),
        .stall_req(stall_req), .result_valid(result_valid),
        .lo_we(lo_we), .lo_wdata(lo_wdata), .hi_we(hi_we), .hi_wdata(hi_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ua, ub, q0, r0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            ua = (s && a[31]) ? (32'd0 - a) : a;
            ub = (s && b[31]) ? (32'd0 - b) : b;
            q0 = ua / ub;
            r0 = ua % ub;
            q  = (s && (a[31] ^ b[31])) ? (32'd0 - q0) : q0;
            r  = (s && a[31]) ? (32'd0 - r0) : r0;
        end
    endfunction

    function automatic bit m_idle();
        return !m_done && busy_left == 0;
    endfunction

    always @(posedge clk) begin
        if (rst || annul) begin
            busy_left = 0;
            m_done    = 1'b0;
        end else if (m_idle()) begin
            if (start) begin
                calc(dividend, divisor, signed_op, m_lo, m_hi);
                if (divisor == 32'd0) m_done = 1'b1;
                else                  busy_left = 32;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) m_done = 1'b1;
        end else if (m_done && !hold) begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_req", {31'd0, stall_req}, {31'd0, !annul && ((m_idle() && start) || busy_left > 0)});
            chk("result_valid", {31'd0, result_valid}, {31'd0, m_done});
            chk("lo_we", {31'd0, lo_we}, {31'd0, m_done});
            chk("hi_we", {31'd0, hi_we}, {31'd0, m_done});
            if (m_done) begin
                chk("lo_wdata", lo_wdata, m_lo);
                chk("hi_wdata", hi_wdata, m_hi);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after a posedge with the DUT back in IDLE unless hold is set.
    task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int exp_lat, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 1;
        while (!result_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " lo"}, lo_wdata, eq);
        chk({nm, " hi"}, hi_wdata, er);
        if (!hold) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic watch_no_valid(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        logic [31:0] lo_keep, hi_keep;
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; annul = 1'b0; hold = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset valid", {31'd0, result_valid}, 32'd0);
        chk("reset stall", {31'd0, stall_req}, 32'd0);
        chk("reset lo", lo_wdata, 32'd0);
        chk("reset hi", hi_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1);
        run_div("divu 5/0", 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5);
        run_div("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0);
        run_div("divu big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 33, 32'h0000_FFFF, 32'h0000_FFFF);

        // Result must stay put through three held cycles and drop one cycle after release.
        hold = 1'b1;
        run_div("hold 1000/3", 32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1);
        lo_keep = lo_wdata; hi_keep = hi_wdata;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold valid", {31'd0, result_valid}, 32'd1);
            chk("hold lo", lo_wdata, lo_keep);
            chk("hold hi", hi_wdata, hi_keep);
        end
        hold = 1'b0;
        @(posedge clk); #1;
        chk("hold release", {31'd0, result_valid}, 32'd0);

        start = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        annul = 1'b1;
        #2 chk("annul stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul idle stall", {31'd0, stall_req}, 32'd0);
        watch_no_valid("annul no result", 40);

        start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
        #2 chk("start+annul stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        watch_no_valid("start+annul no result", 40);

        start = 1'b1; dividend = 32'd77; divisor = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst mid stall", {31'd0, stall_req}, 32'd0);
        watch_no_valid("rst mid no result", 40);

        run_div("after rst 81/9", 32'd81, 32'd9, 1'b1, 33, 32'd9, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 3) != 0);
            signed_op = $urandom_range(0, 1);
            dividend  = $urandom;
            case ($urandom_range(0, 5))
                0:       divisor = 32'd0;
                1:       divisor = $urandom_range(1, 15);
                2:       divisor = 32'hFFFF_FFFF;
                default: divisor = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) dividend = 32'h8000_0000;
            annul = ($urandom_range(0, 199) == 0);
            hold  = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 799) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0; annul = 1'b0; hold = 1'b0; rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
